// File: rtl/ldpc_tx_encoder.sv
// (6,3) LDPC transmit encoder: buffered 3-bit messages, serialized LSB-first codewords.
// Define LDPC_TX_ERR_INJ_EN to add the inj_en/inj_pos single-bit error injection ports.
module ldpc_tx_encoder #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_sof,
  output logic             tx_eof,
  input  logic             tx_ready,
  output logic [5:0]       cw_out,
  output logic [CNT_W-1:0] cw_count,
  output logic             busy
`ifdef LDPC_TX_ERR_INJ_EN
  ,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             avail;
  logic             push, pop, xfer, last_xfer;
  logic [5:0]       shreg, head_cw;
  logic [2:0]       idx;

  function automatic logic [5:0] encode(input logic [2:0] m);
    return {m[0] ^ m[2], m[1] ^ m[2], m[0] ^ m[1], m};
  endfunction

  always_comb begin
    head_cw = encode(mem[rptr]);
`ifdef LDPC_TX_ERR_INJ_EN
    if (inj_en && (inj_pos < 3'd6))
      head_cw = head_cw ^ (6'b000001 << inj_pos);
`endif
  end

  assign push      = msg_valid && msg_ready;
  assign xfer      = tx_valid && tx_ready;
  assign last_xfer = xfer && (idx == 3'd5);
  assign pop       = avail && ((state == IDLE) || last_xfer);
  assign occ_nxt   = occ + OCC_W'(push) - OCC_W'(pop);
  assign busy      = (occ != '0) || (state == SEND);
  assign tx_valid  = (state == SEND);
  assign tx_bit    = shreg[0];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= msg_in;
  end

  // avail excludes an entry written on the same edge, so a fresh message waits one
  // extra cycle before it can be popped (accept-to-first-bit latency of two cycles).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      avail     <= 1'b0;
      msg_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      occ       <= occ_nxt;
      msg_ready <= (occ_nxt != OCC_W'(FIFO_DEPTH));
      avail     <= ((occ - OCC_W'(pop)) != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      cw_out   <= '0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
      cw_count <= '0;
    end else begin
      if (last_xfer) cw_count <= cw_count + CNT_W'(1);
      if (pop) begin
        state  <= SEND;
        shreg  <= head_cw;
        cw_out <= head_cw;
        idx    <= '0;
        tx_sof <= 1'b1;
        tx_eof <= 1'b0;
      end else if (last_xfer) begin
        state  <= IDLE;
        shreg  <= '0;
        tx_sof <= 1'b0;
        tx_eof <= 1'b0;
      end else if (xfer) begin
        shreg  <= {1'b0, shreg[5:1]};
        idx    <= idx + 3'd1;
        tx_sof <= 1'b0;
        tx_eof <= (idx == 3'd4);
      end
    end
  end

endmodule

// File: tb/tb_ldpc_tx_encoder.sv
// Directed bench for ldpc_tx_encoder (FIFO_DEPTH=2, CNT_W=4 to exercise counter wrap).
module tb_ldpc_tx_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] msg_in;
  logic       msg_valid;
  logic       msg_ready;
  logic       tx_bit, tx_valid, tx_sof, tx_eof;
  logic       tx_ready;
  logic [5:0] cw_out;
  logic [3:0] cw_count;
  logic       busy;
`ifdef LDPC_TX_ERR_INJ_EN
  logic       inj_en;
  logic [2:0] inj_pos;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_count;

  always #5 clk = ~clk;

  ldpc_tx_encoder #(.FIFO_DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_ready(tx_ready), .cw_out(cw_out), .cw_count(cw_count), .busy(busy)
`ifdef LDPC_TX_ERR_INJ_EN
    , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input logic [2:0] m);
    msg_in    = m;
    msg_valid = 1'b1;
    for (int i = 0; i < 50 && !msg_ready; i++) tick();
    total++;
    if (msg_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_wait: msg_ready=%b required 1", msg_ready);
    end
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msg_valid = 1'b0; msg_in = '0; tx_ready = 1'b1;
`ifdef LDPC_TX_ERR_INJ_EN
    inj_en = 1'b0; inj_pos = '0;
`endif
    tick(); tick();
    total++;
    if ({tx_valid, tx_bit, tx_sof, tx_eof, busy, msg_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: {valid,bit,sof,eof,busy,ready}=%b required 000000",
               {tx_valid, tx_bit, tx_sof, tx_eof, busy, msg_ready});
    end
    total++;
    if (cw_out !== 6'd0 || cw_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_regs: cw_out=%b cw_count=%0d required 0/0", cw_out, cw_count);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (msg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_rise: msg_ready=%b required 1", msg_ready);
    end
    exp_count = '0;
  endtask

  task automatic test_single();
    logic [5:0] exp_cw = 6'b011101;
    msg_in = 3'b101; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL latency_e0: valid=%b busy=%b required 0/1", tx_valid, busy);
    end
    tick();
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_e1: valid=%b required 0", tx_valid);
    end
    tick();
    total++;
    if (tx_valid !== 1'b1 || tx_sof !== 1'b1 || cw_out !== exp_cw) begin
      bad++;
      $display("FAIL latency_e2: valid=%b sof=%b cw_out=%b required 1/1/%b",
               tx_valid, tx_sof, cw_out, exp_cw);
    end
    total++;
    if ({^(cw_out & 6'b001011), ^(cw_out & 6'b010110), ^(cw_out & 6'b100101)} !== 3'b000) begin
      bad++;
      $display("FAIL single_syndrome: cw_out=%b has nonzero syndrome", cw_out);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({tx_valid, tx_bit, tx_sof, tx_eof} !== {1'b1, exp_cw[i], (i == 0), (i == 5)}) begin
        bad++;
        $display("FAIL single_bit%0d: {valid,bit,sof,eof}=%b required %b", i,
                 {tx_valid, tx_bit, tx_sof, tx_eof}, {1'b1, exp_cw[i], (i == 0), (i == 5)});
      end
      tick();
    end
    exp_count = exp_count + 4'd1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || cw_count !== exp_count) begin
      bad++;
      $display("FAIL single_end: valid=%b busy=%b cw_count=%0d required 0/0/%0d",
               tx_valid, busy, cw_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] s = {6'b101110, 6'b110011};
    msg_valid = 1'b1; msg_in = 3'b011;
    tick();
    msg_in = 3'b110;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    total++;
    if (tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start: tx_valid=%b required 1", tx_valid);
    end
    for (int k = 0; k < 12; k++) begin
      total++;
      if ({tx_valid, tx_bit, tx_sof} !== {1'b1, s[k], (k % 6 == 0)}) begin
        bad++;
        $display("FAIL b2b_bit%0d: {valid,bit,sof}=%b required %b", k,
                 {tx_valid, tx_bit, tx_sof}, {1'b1, s[k], (k % 6 == 0)});
      end
      if (k == 0 || k == 6) begin
        total++;
        if (cw_out !== ((k == 0) ? 6'b110011 : 6'b101110)) begin
          bad++;
          $display("FAIL b2b_cw%0d: cw_out=%b required %b", k, cw_out,
                   (k == 0) ? 6'b110011 : 6'b101110);
        end
      end
      tick();
    end
    exp_count = exp_count + 4'd2;
    total++;
    if (tx_valid !== 1'b0 || cw_count !== exp_count) begin
      bad++;
      $display("FAIL b2b_end: valid=%b cw_count=%0d required 0/%0d", tx_valid, cw_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0]  cws [4] = '{6'b101001, 6'b011010, 6'b110100, 6'b000111};
    logic [2:0]  msgs[4] = '{3'b001, 3'b010, 3'b100, 3'b111};
    logic [23:0] got = '0;
    logic [8:0]  saved = '0;
    logic        prev_hold = 1'b0;
    int          nbits = 0;
    int          npush = 3;
    tx_ready = 1'b0;
    push_msg(msgs[0]);
    push_msg(msgs[1]);
    push_msg(msgs[2]);
    tick();
    total++;
    if (msg_ready !== 1'b0 || tx_valid !== 1'b1 || tx_sof !== 1'b1 || cw_out !== cws[0]) begin
      bad++;
      $display("FAIL bp_full: ready=%b valid=%b sof=%b cw_out=%b required 0/1/1/%b",
               msg_ready, tx_valid, tx_sof, cw_out, cws[0]);
    end
    for (int cyc = 0; cyc < 300 && nbits < 24; cyc++) begin
      if (prev_hold) begin
        total++;
        if ({tx_bit, tx_sof, tx_eof, cw_out} !== saved) begin
          bad++;
          $display("FAIL bp_hold: {bit,sof,eof,cw}=%b required %b",
                   {tx_bit, tx_sof, tx_eof, cw_out}, saved);
        end
      end
      tx_ready = cyc[0];
      if (tx_valid && tx_sof) begin
        total++;
        if (cw_out !== cws[nbits / 6]) begin
          bad++;
          $display("FAIL bp_frame%0d: cw_out=%b required %b", nbits / 6, cw_out, cws[nbits / 6]);
        end
      end
      if (tx_valid && tx_ready) begin
        got[nbits] = tx_bit;
        nbits++;
      end
      prev_hold = tx_valid && !tx_ready;
      saved     = {tx_bit, tx_sof, tx_eof, cw_out};
      if (npush < 4) begin
        msg_valid = 1'b1;
        msg_in    = msgs[npush];
        if (msg_ready) npush++;
      end else begin
        msg_valid = 1'b0;
      end
      tick();
    end
    msg_valid = 1'b0;
    tx_ready  = 1'b1;
    total++;
    if (nbits != 24 || npush != 4 || got !== {cws[3], cws[2], cws[1], cws[0]}) begin
      bad++;
      $display("FAIL bp_stream: bits=%0d pushes=%0d got=%b required 24/4/%b",
               nbits, npush, got, {cws[3], cws[2], cws[1], cws[0]});
    end
    tick(); tick();
    exp_count = exp_count + 4'd4;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || cw_count !== exp_count) begin
      bad++;
      $display("FAIL bp_end: valid=%b busy=%b cw_count=%0d required 0/0/%0d",
               tx_valid, busy, cw_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b1;
    msg_valid = 1'b1; msg_in = 3'b101;
    tick();
    msg_in = 3'b011;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 10 && !tx_sof; i++) tick();
    tick(); tick(); tick();
    total++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1 || busy !== 1'b1 || cw_count === 4'd0) begin
      bad++;
      $display("FAIL rstmid_pre: valid=%b bit=%b busy=%b cw_count=%0d required 1/1/1/nonzero",
               tx_valid, tx_bit, busy, cw_count);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({tx_valid, tx_bit, tx_sof, tx_eof, busy, msg_ready} !== 6'b0 ||
        cw_out !== 6'd0 || cw_count !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_reset: flags=%b cw_out=%b cw_count=%0d required 000000/0/0",
               {tx_valid, tx_bit, tx_sof, tx_eof, busy, msg_ready}, cw_out, cw_count);
    end
    rst_n = 1'b1;
    exp_count = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_quiet%0d: valid=%b busy=%b required 0/0", i, tx_valid, busy);
      end
    end
  endtask

  task automatic test_wrap();
    logic eofx;
    int   nsent  = 0;
    int   frames = 0;
    tx_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && frames < 17; cyc++) begin
      eofx = tx_valid && tx_eof && tx_ready;
      if (nsent < 17) begin
        msg_valid = 1'b1;
        msg_in    = nsent[2:0];
        if (msg_ready) nsent++;
      end else begin
        msg_valid = 1'b0;
      end
      tick();
      if (eofx) begin
        frames++;
        exp_count = exp_count + 4'd1;
        total++;
        if (cw_count !== exp_count) begin
          bad++;
          $display("FAIL wrap_frame%0d: cw_count=%0d required %0d", frames, cw_count, exp_count);
        end
        if (frames == 16) begin
          total++;
          if (cw_count !== 4'd0) begin
            bad++;
            $display("FAIL wrap_16: cw_count=%0d required 0", cw_count);
          end
        end
      end
    end
    msg_valid = 1'b0;
    total++;
    if (frames != 17 || cw_count !== 4'd1) begin
      bad++;
      $display("FAIL wrap_17: frames=%0d cw_count=%0d required 17/1", frames, cw_count);
    end
  endtask

`ifdef LDPC_TX_ERR_INJ_EN
  task automatic test_err_inj();
    logic       ens [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] poss[3] = '{3'd4, 3'd6, 3'd4};
    logic [5:0] exps[3] = '{6'b001101, 6'b011101, 6'b011101};
    logic [5:0] e;
    tx_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      inj_en = ens[t]; inj_pos = poss[t]; e = exps[t];
      msg_valid = 1'b1; msg_in = 3'b101;
      tick();
      msg_valid = 1'b0;
      for (int i = 0; i < 10 && !tx_sof; i++) tick();
      total++;
      if (tx_sof !== 1'b1 || cw_out !== e) begin
        bad++;
        $display("FAIL inj%0d_cw: sof=%b cw_out=%b required 1/%b", t, tx_sof, cw_out, e);
      end
      if (t == 0) begin
        total++;
        if ({^(cw_out & 6'b100101), ^(cw_out & 6'b010110), ^(cw_out & 6'b001011)} !== 3'b010) begin
          bad++;
          $display("FAIL inj0_syndrome: {c2,c1,c0} of %b not 010", cw_out);
        end
      end
      for (int i = 0; i < 6; i++) begin
        total++;
        if (tx_bit !== e[i]) begin
          bad++;
          $display("FAIL inj%0d_bit%0d: tx_bit=%b required %b", t, i, tx_bit, e[i]);
        end
        tick();
      end
      exp_count = exp_count + 4'd1;
      total++;
      if (cw_count !== exp_count) begin
        bad++;
        $display("FAIL inj%0d_count: cw_count=%0d required %0d", t, cw_count, exp_count);
      end
    end
    inj_en = 1'b0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
`ifdef LDPC_TX_ERR_INJ_EN
    test_err_inj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
